vga_frame_engine: RTL
=====================

Name: vga_frame_engine

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates configurable VGA timing and fetches image pixels from a synchronous-read pixel memory (ROM or RAM) with integer upscaling. It pipelines sync and blank to match memory latency and provides test-pattern modes. It sits between the pixel clock divider and the pixel memories, and drives the DAC pins directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal porch and sync widths in pixel clocks
V_ACTIVE, 480, visible lines
V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical porch and sync widths in lines
HSYNC_POL, 0 / VSYNC_POL, 0, sync active level (0 = active-low)
COLOR_W, 8, bits per colour channel
IMG_W, 256 / IMG_H, 256, stored image size in pixels
SCALE, 1, integer upscale factor, legal range 1..8
ADDR_W, 32, pixel memory address width
MEM_LAT, 1, pixel memory read latency in cycles, legal range 1..4

Ports:
clock_25  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
start  in  1  level or pulse; arms display from the next frame
mode  in  2  0=image, 1=colour bars, 2=solid white, 3=black
pixel_data  in  3*COLOR_W  {R,G,B} from memory, valid MEM_LAT cycles after address
address  out  ADDR_W  pixel memory read address
red/green/blue  out  COLOR_W each  colour to DAC
hsync, vsync  out  1  sync pulses at the configured polarity
n_blank  out  1  high during the visible area of a displayed frame
frame_start  out  1  one-cycle pulse aligned with the first visible pixel at the pins

Behaviour:
- Reset (asynchronous assert, synchronous release to the clock_25 edge): h_cnt=v_cnt=0, state IDLE, address=0, red/green/blue=0, n_blank=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL. Every pipeline register is cleared.
- Counters: h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), then wraps; v_cnt increments on h wrap and runs 0..V_TOTAL-1. Visible area is h<H_ACTIVE and v<V_ACTIVE. hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is defined the same way on v.
- Counters and syncs run in every state, so the monitor stays locked.
- FSM:
  - IDLE: n_blank=0, colour=0. start=1 moves to ARMED.
  - ARMED: waits for h_cnt=0 and v_cnt=0, then moves to DISPLAY.
  - DISPLAY: normal output. No exit except reset. start is ignored outside IDLE.
  - reset mid-frame returns to IDLE immediately.
- Image window: x<IMG_W*SCALE and y<IMG_H*SCALE, placed at the top-left. Visible pixels outside the window output 0 in image mode.
- Addressing uses no divider or multiplier:
  - sub-counters sx and sy run 0..SCALE-1.
  - col advances when sx wraps.
  - row_base advances by IMG_W when both sy and the line wrap.
  - address = row_base + col. It resets to 0 at h=0 of line 0, and col resets at each line start.
  - Outside the window address holds its last value.
  - Each pixel is repeated SCALE times horizontally and each row SCALE lines vertically.
- Pipeline: output registers sit MEM_LAT+1 cycles after counter stage 0. hsync, vsync, n_blank, in-window flag, mode and frame_start are all delayed by the same depth, so colour and sync stay aligned in every mode.
- Colour bars: eight bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0. The last bar absorbs any remainder.
- Solid white: all channels all-ones. Black: all 0. In both cases sync and n_blank run normally.
- A mode change takes effect from the next pixel entering stage 0; no glitch rules apply beyond pipeline alignment.
- frame_start: one pulse per displayed frame at pin-time coordinates (0,0). It is never pulsed in IDLE or ARMED.

Test Plan:
- Reset released, start=0, defaults: hsync period 800 cycles, low for 96 cycles starting at h=656; vsync period 525 lines, low for 2 lines; n_blank=0 and RGB=0 throughout.
- start pulse at v=100 -> no output until next frame; frame_start fires once, 2 cycles after counters reach (0,0); n_blank high exactly for 640x480 cycles per frame.
- mode=0, SCALE=2, IMG_W=IMG_H=4, memory returns data=address -> pixels (0..7, line 0) show 0,0,1,1,2,2,3,3; lines 0 and 1 identical; line 2 begins at address 4; x>=8 or y>=8 outputs 0.
- MEM_LAT=3 -> first visible pixel colour is aligned with the n_blank rising edge; latency from counter to pins is 4 cycles; sync edges shift by the same 4 cycles.
- mode=1 -> x=0..79 gives FF/FF/FF, x=80 gives FF/FF/00, x=560..639 gives 00/00/00.
- reset asserted mid-line in DISPLAY -> all outputs take reset values asynchronously; after release the state is IDLE and display needs a new start.

Source files
------------

// File: rtl/vga_frame_engine_if.sv
// Pixel memory read port of the VGA frame engine.
//   address    : read address, driven by the engine (master)
//   pixel_data : {R,G,B} returned by the memory MEM_LAT cycles after address
interface vga_frame_engine_if #(
   parameter int ADDR_W  = 32,
   parameter int COLOR_W = 8
);
   logic [ADDR_W-1:0]    address;
   logic [3*COLOR_W-1:0] pixel_data;

   modport master (output address, input pixel_data);
   modport slave  (input address, output pixel_data);
endinterface

// File: rtl/vga_frame_engine.sv
// VGA frame engine: configurable timing generator with an upscaled image
// fetch from a synchronous-read pixel memory, plus test-pattern modes.
// Ports:
//   clock_25     pixel clock
//   reset        asynchronous active-low reset
//   start        arms display from the next frame (only sampled in IDLE)
//   mode         0=image, 1=colour bars, 2=solid white, 3=black
//   mem          pixel memory read port (address out, pixel_data in)
//   red/green/blue  colour to DAC
//   hsync/vsync  sync pulses at configured polarity
//   n_blank      high during the visible area of a displayed frame
//   frame_start  one-cycle pulse with the first visible pixel at the pins
module vga_frame_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int COLOR_W   = 8,
   parameter int IMG_W     = 256,
   parameter int IMG_H     = 256,
   parameter int SCALE     = 1,
   parameter int ADDR_W    = 32,
   parameter int MEM_LAT   = 1
) (
   input  logic               clock_25,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   vga_frame_engine_if.master mem,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               hsync,
   output logic               vsync,
   output logic               n_blank,
   output logic               frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int SW      = $clog2(SCALE + 1);
   localparam int CW3     = 3 * COLOR_W;
   localparam int BAR_W   = H_ACTIVE / 8;
   // Window clipped to the visible area so in-window implies visible.
   localparam int WIN_W   = (IMG_W * SCALE < H_ACTIVE) ? IMG_W * SCALE : H_ACTIVE;
   localparam int WIN_H   = (IMG_H * SCALE < V_ACTIVE) ? IMG_H * SCALE : V_ACTIVE;

   localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0]     H_VIS    = HW'(H_ACTIVE);
   localparam logic [VW-1:0]     V_VIS    = VW'(V_ACTIVE);
   localparam logic [HW-1:0]     H_WIN    = HW'(WIN_W);
   localparam logic [VW-1:0]     V_WIN    = VW'(WIN_H);
   localparam logic [HW-1:0]     HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0]     S_LAST   = SW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'((IMG_H - 1) * IMG_W);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   typedef enum logic [1:0] {IDLE, ARMED, DISPLAY} state_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       nb;
      logic       win;
      logic       fs;
      logic [1:0] mode;
      logic [2:0] bar;
   } ctrl_t;

   localparam ctrl_t CTRL_RST = ctrl_t'({~HSYNC_POL, ~VSYNC_POL, 8'b0});

   state_t              state_q;
   logic [HW-1:0]       h_cnt_q, h_cnt_d;
   logic [VW-1:0]       v_cnt_q, v_cnt_d;
   logic [SW-1:0]       sx_q, sx_d, sy_q, sy_d;
   logic [ADDR_W-1:0]   col_q, col_d, row_base_q, row_base_d;
   logic                h_wrap, v_wrap, in_win_v, in_win;
   logic [2:0]          bar0;
   ctrl_t               ctrl0;
   ctrl_t               pipe_q [MEM_LAT];
   ctrl_t               c_out;
   logic [CW3-1:0]      rgb_d, rgb_q;
   logic                hs_q, vs_q, nb_q, fs_q;

   assign h_wrap   = (h_cnt_q == H_LAST);
   assign v_wrap   = (v_cnt_q == V_LAST);
   assign in_win_v = (v_cnt_q < V_WIN);
   assign in_win   = in_win_v && (h_cnt_q < H_WIN);

   // Address tracks the pixel currently at stage 0; the memory answers
   // MEM_LAT cycles later, when that pixel's control reaches the pipe tail.
   assign mem.address = row_base_q + col_q;

   // Counters and the divider-free scaling sub-counters.
   always_comb begin
      h_cnt_d    = h_cnt_q + 1'b1;
      v_cnt_d    = v_cnt_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      if (h_wrap) begin
         h_cnt_d = '0;
         sx_d    = '0;
         col_d   = '0;
         if (v_wrap) begin
            v_cnt_d    = '0;
            sy_d       = '0;
            row_base_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 1'b1;
            if (in_win_v) begin
               if (sy_q == S_LAST) begin
                  sy_d = '0;
                  // Stop on the last image row so the address holds below the window.
                  if (row_base_q != ROW_LAST) row_base_d = row_base_q + ROW_STEP;
               end else begin
                  sy_d = sy_q + 1'b1;
               end
            end
         end
      end else if (in_win) begin
         if (sx_q == S_LAST) begin
            sx_d = '0;
            if (col_q != COL_LAST) col_d = col_q + 1'b1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         col_q      <= '0;
         row_base_q <= '0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
      end
   end

   // ARMED leaves on the last pixel of a frame so that (0,0) is already
   // displayed and carries frame_start.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_q <= ARMED;
            ARMED:   if (h_wrap && v_wrap) state_q <= DISPLAY;
            DISPLAY: state_q <= DISPLAY;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bar index by threshold compare; the last bar takes any remainder.
   always_comb begin
      bar0 = '0;
      for (int i = 1; i < 8; i++)
         if (h_cnt_q >= HW'(i * BAR_W)) bar0 = 3'(i);
   end

   always_comb begin
      ctrl0      = CTRL_RST;
      ctrl0.hs   = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      ctrl0.vs   = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      ctrl0.nb   = (state_q == DISPLAY) && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      ctrl0.win  = in_win;
      ctrl0.fs   = (state_q == DISPLAY) && (h_cnt_q == '0) && (v_cnt_q == '0);
      ctrl0.mode = mode;
      ctrl0.bar  = bar0;
   end

   // MEM_LAT stages of control, then the output register below.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= CTRL_RST;
      end else begin
         pipe_q[0] <= ctrl0;
         for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign c_out = pipe_q[MEM_LAT-1];

   // Bar colour bits {R,G,B} = {~bar[1], ~bar[2], ~bar[0]} gives
   // white, yellow, cyan, green, magenta, red, blue, black.
   always_comb begin
      rgb_d = '0;
      if (c_out.nb) begin
         case (c_out.mode)
            2'd0:    if (c_out.win) rgb_d = mem.pixel_data;
            2'd1:    rgb_d = {{COLOR_W{~c_out.bar[1]}}, {COLOR_W{~c_out.bar[2]}},
                              {COLOR_W{~c_out.bar[0]}}};
            2'd2:    rgb_d = '1;
            default: rgb_d = '0;
         endcase
      end
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         rgb_q <= '0;
         hs_q  <= ~HSYNC_POL;
         vs_q  <= ~VSYNC_POL;
         nb_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= c_out.hs;
         vs_q  <= c_out.vs;
         nb_q  <= c_out.nb;
         fs_q  <= c_out.fs;
      end
   end

   assign red         = rgb_q[CW3-1 -: COLOR_W];
   assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign blue        = rgb_q[COLOR_W-1:0];
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign n_blank     = nb_q;
   assign frame_start = fs_q;
endmodule
